main_control_fsm: RTL and testbench

- Multi-cycle MIPS main control unit.
- Decodes the 6-bit opcode and sequences fetch / decode / execute / memory / writeback.
- Drives the datapath enables and muxes.
- Produces the 2-bit ALUOp consumed by the ALU decoder, which turns ALUOp+Funct into ALUSel.
- Encoding side of the ALUOp interface: 00 = add (address/PC), 01 = subtract (BEQ), 10 = R-type (use Funct).

---
 rtl/main_control_fsm_pkg.sv | 42 ++++
 rtl/main_control_fsm.sv | 146 ++++++++++++++
 tb/tb_main_control_fsm.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/main_control_fsm_pkg.sv
// Shared encodings for the multi-cycle MIPS main control FSM and the ALU decoder.
// Opcodes, ALUOp codes, datapath mux selects and the controller state enumeration.
package main_control_fsm_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALURES = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // HALT is only reachable when the illegal-opcode trap is built in.
  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11,
    HALT    = 4'd12
  } state_e;

endpackage

// File: rtl/main_control_fsm.sv
// Multi-cycle MIPS main control: Moore FSM, outputs decoded from state (+MemReady), forced 0 in reset.
// Memory states stall on MemReady=0; MAIN_CTRL_ILLEGAL_TRAP_EN adds sticky IllegalOp and a HALT state.
module main_control_fsm
  import main_control_fsm_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [5:0] Opcode,
  input  logic       MemReady,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic       PCWrite,
  output logic       Branch
`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
  ,
  output logic       IllegalOp
`endif
);

  logic [STATE_W-1:0] state_q, state_d;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= FETCH;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:   state_d = MemReady ? DECODE : FETCH;
      DECODE: begin
        case (Opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
          default:      state_d = HALT;
`else
          default:      state_d = FETCH;
`endif
        endcase
      end
      MEMADR:  state_d = (Opcode == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   state_d = MemReady ? MEMWB : MEMRD;
      MEMWB:   state_d = FETCH;
      MEMWR:   state_d = MemReady ? FETCH : MEMWR;
      EXECUTE: state_d = ALUWB;
      ALUWB:   state_d = FETCH;
      BRANCH:  state_d = FETCH;
      ADDIEX:  state_d = ADDIWB;
      ADDIWB:  state_d = FETCH;
      JUMP:    state_d = FETCH;
`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
      HALT:    state_d = HALT;
`endif
      default: state_d = FETCH;
    endcase
  end

`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
  logic illegal_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)                                      illegal_q <= 1'b0;
    else if ((state_q == DECODE) && (state_d == HALT)) illegal_q <= 1'b1;
  end

  assign IllegalOp = illegal_q;
`endif

  // Reset_n gates the decode directly so strobes drop asynchronously with reset.
  always_comb begin
    IorD     = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = SRCB_REG;
    ALUOp    = ALUOP_ADD;
    PCSrc    = PCSRC_ALURES;
    PCWrite  = 1'b0;
    Branch   = 1'b0;
    if (Reset_n) begin
      case (state_q)
        FETCH: begin
          ALUSrcB = SRCB_FOUR;
          IRWrite = MemReady;
          PCWrite = MemReady;
        end
        DECODE: ALUSrcB = SRCB_IMMSH;
        MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
        end
        MEMRD:  IorD = 1'b1;
        MEMWB: begin
          MemtoReg = 1'b1;
          RegWrite = 1'b1;
        end
        MEMWR: begin
          IorD     = 1'b1;
          MemWrite = 1'b1;
        end
        EXECUTE: begin
          ALUSrcA = 1'b1;
          ALUOp   = ALUOP_FUNCT;
        end
        ALUWB: begin
          RegDst   = 1'b1;
          RegWrite = 1'b1;
        end
        BRANCH: begin
          ALUSrcA = 1'b1;
          ALUOp   = ALUOP_SUB;
          PCSrc   = PCSRC_ALUOUT;
          Branch  = 1'b1;
        end
        ADDIEX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
        end
        ADDIWB: RegWrite = 1'b1;
        JUMP: begin
          PCSrc   = PCSRC_JUMP;
          PCWrite = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_main_control_fsm.sv
// Directed bench for main_control_fsm; expected outputs per state are hand-coded below.
// Honours MAIN_CTRL_ILLEGAL_TRAP_EN to check the IllegalOp/HALT behaviour when built in.
module tb_main_control_fsm;

  localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3, S_MEMWB = 4,
                 S_MEMWR = 5, S_EXECUTE = 6, S_ALUWB = 7, S_BRANCH = 8, S_ADDIEX = 9,
                 S_ADDIWB = 10, S_JUMP = 11, S_HALT = 12;

  logic       Clk, Reset_n, MemReady;
  logic [5:0] Opcode;
  logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCWrite, Branch;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;
`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
  logic       IllegalOp;
`endif

  int checks = 0;
  int errors = 0;

  main_control_fsm dut (
    .Clk(Clk), .Reset_n(Reset_n), .Opcode(Opcode), .MemReady(MemReady),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .PCSrc(PCSrc), .PCWrite(PCWrite), .Branch(Branch)
`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
    , .IllegalOp(IllegalOp)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic [14:0] outs;
  assign outs = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                 ALUSrcB, ALUOp, PCSrc, PCWrite, Branch};

  function automatic logic [14:0] exp_out(input int st, input logic mr);
    logic iord, mw, irw, rd, m2r, rw, sa, pw, br;
    logic [1:0] sb, op, pc;
    {iord, mw, irw, rd, m2r, rw, sa, pw, br} = '0;
    sb = 2'b00; op = 2'b00; pc = 2'b00;
    case (st)
      S_FETCH:   begin sb = 2'b01; irw = mr; pw = mr; end
      S_DECODE:  sb = 2'b11;
      S_MEMADR:  begin sa = 1'b1; sb = 2'b10; end
      S_MEMRD:   iord = 1'b1;
      S_MEMWB:   begin m2r = 1'b1; rw = 1'b1; end
      S_MEMWR:   begin iord = 1'b1; mw = 1'b1; end
      S_EXECUTE: begin sa = 1'b1; op = 2'b10; end
      S_ALUWB:   begin rd = 1'b1; rw = 1'b1; end
      S_BRANCH:  begin sa = 1'b1; op = 2'b01; pc = 2'b01; br = 1'b1; end
      S_ADDIEX:  begin sa = 1'b1; sb = 2'b10; end
      S_ADDIWB:  rw = 1'b1;
      S_JUMP:    begin pc = 2'b10; pw = 1'b1; end
      default:   ;
    endcase
    return {iord, mw, irw, rd, m2r, rw, sa, sb, op, pc, pw, br};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at posedge+1: apply MemReady, check state outputs, advance one cycle.
  task automatic cyc(input int st, input logic mr, input string tag);
    MemReady = mr;
    #1;
    check(tag, {17'b0, outs}, {17'b0, exp_out(st, mr)});
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Reset_n  = 1'b0;
    MemReady = 1'b1;
    Opcode   = 6'b000000;
    #3;
    check("reset_outs", {17'b0, outs}, 32'h0);
    repeat (2) @(posedge Clk);
    #1;
    check("reset_outs_clocked", {17'b0, outs}, 32'h0);
`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
    check("illegal_reset", {31'b0, IllegalOp}, 32'h0);
`endif
    Reset_n = 1'b1;

    cyc(S_FETCH, 1'b0, "fetch_wait0");
    cyc(S_FETCH, 1'b0, "fetch_wait1");

    Opcode = 6'b100011;
    cyc(S_FETCH, 1'b1, "lw_c1"); cyc(S_DECODE, 1'b1, "lw_c2"); cyc(S_MEMADR, 1'b1, "lw_c3");
    cyc(S_MEMRD, 1'b1, "lw_c4"); cyc(S_MEMWB, 1'b1, "lw_c5");

    Opcode = 6'b000000;
    cyc(S_FETCH, 1'b1, "rt_c1"); cyc(S_DECODE, 1'b1, "rt_c2");
    cyc(S_EXECUTE, 1'b1, "rt_c3"); cyc(S_ALUWB, 1'b1, "rt_c4");

    Opcode = 6'b000100;
    cyc(S_FETCH, 1'b1, "beq_c1"); cyc(S_DECODE, 1'b1, "beq_c2"); cyc(S_BRANCH, 1'b1, "beq_c3");

    Opcode = 6'b001000;
    cyc(S_FETCH, 1'b1, "addi_c1"); cyc(S_DECODE, 1'b1, "addi_c2");
    cyc(S_ADDIEX, 1'b1, "addi_c3"); cyc(S_ADDIWB, 1'b1, "addi_c4");

    Opcode = 6'b000010;
    cyc(S_FETCH, 1'b1, "j_c1"); cyc(S_DECODE, 1'b1, "j_c2"); cyc(S_JUMP, 1'b1, "j_c3");

    Opcode = 6'b101011;
    cyc(S_FETCH, 1'b1, "sw_c1"); cyc(S_DECODE, 1'b1, "sw_c2"); cyc(S_MEMADR, 1'b1, "sw_c3");
    for (int i = 0; i < 3; i++) cyc(S_MEMWR, 1'b0, $sformatf("sw_wait%0d", i));
    cyc(S_MEMWR, 1'b1, "sw_done");
    cyc(S_FETCH, 1'b0, "sw_back_fetch");

    Opcode = 6'b100011;
    cyc(S_FETCH, 1'b1, "lwst_c1"); cyc(S_DECODE, 1'b1, "lwst_c2"); cyc(S_MEMADR, 1'b1, "lwst_c3");
    cyc(S_MEMRD, 1'b0, "lwst_wait"); cyc(S_MEMRD, 1'b1, "lwst_rd"); cyc(S_MEMWB, 1'b1, "lwst_wb");

    // Asynchronous reset while MemWrite is asserted.
    Opcode = 6'b101011;
    cyc(S_FETCH, 1'b1, "swr_c1"); cyc(S_DECODE, 1'b1, "swr_c2"); cyc(S_MEMADR, 1'b1, "swr_c3");
    MemReady = 1'b0;
    #1;
    check("swr_memwrite_hi", {31'b0, MemWrite}, 32'h1);
    #2;
    Reset_n = 1'b0;
    #1;
    check("swr_async_outs", {17'b0, outs}, 32'h0);
    @(posedge Clk);
    #1;
    check("swr_held_outs", {17'b0, outs}, 32'h0);
    Reset_n = 1'b1;
    cyc(S_FETCH, 1'b0, "swr_release_fetch");

    Opcode = 6'b111111;
    cyc(S_FETCH, 1'b1, "ill_c1"); cyc(S_DECODE, 1'b1, "ill_c2");
`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
    check("illegal_set", {31'b0, IllegalOp}, 32'h1);
    for (int i = 0; i < 12; i++) cyc(S_HALT, 1'b1, $sformatf("halt%0d", i));
    check("illegal_sticky", {31'b0, IllegalOp}, 32'h1);
    Reset_n = 1'b0;
    #1;
    check("illegal_cleared", {31'b0, IllegalOp}, 32'h0);
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    Opcode = 6'b000010;
    cyc(S_FETCH, 1'b1, "post_halt_fetch");
`else
    cyc(S_FETCH, 1'b1, "ill_back_fetch");
    cyc(S_DECODE, 1'b1, "ill_decode_again");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
